// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//
// Fetch stage of the multi-cycle MIPS datapath. Takes the current PC from
// program_counter and fetches one word over a request/grant/response
// handshake. The word and its PC go to decode through a valid/ready holding
// register. Only one fetch is ever outstanding.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   pc_address   current PC from program_counter
//   pc_advance   one-cycle pulse; program_counter loads next_address on the
//                edge that ends the pulse
//   imem_req     fetch request (combinational, FETCH state only)
//   imem_addr    fetch address (combinational copy of pc_address)
//   imem_gnt     memory accepts the request this cycle
//   imem_rvalid  response data valid
//   imem_rdata   response data
//   flush        branch/jump redirect; kills the held or in-flight instruction
//   id_ready     decode accepts the held instruction this cycle
//   if_valid     if_instr / if_pc / if_pc_plus4 are valid
//   if_instr     fetched instruction
//   if_pc        address of if_instr
//   if_pc_plus4  if_pc + 4, modulo 2^32
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_address,
    output logic        pc_advance,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]  state_reg,       state_next;
    logic        discard_reg,     discard_next;
    logic [31:0] req_pc_reg,      req_pc_next;
    logic        if_valid_reg,    if_valid_next;
    logic [31:0] if_instr_reg,    if_instr_next;
    logic [31:0] if_pc_reg,       if_pc_next;
    logic [31:0] if_pc_plus4_reg, if_pc_plus4_next;
    logic        pc_advance_reg,  pc_advance_next;

    // -----------------------------------------------------------------------
    // Next-state and request logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        discard_next     = discard_reg;
        req_pc_next      = req_pc_reg;
        if_valid_next    = if_valid_reg;
        if_instr_next    = if_instr_reg;
        if_pc_next       = if_pc_reg;
        if_pc_plus4_next = if_pc_plus4_reg;
        pc_advance_next  = 1'b0;
        imem_req         = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                // A flush this cycle means pc_address is about to be
                // redirected, so no request goes out with the stale PC.
                imem_req = !flush;
                if (imem_gnt && imem_req) begin
                    req_pc_next = pc_address;
                    state_next  = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (imem_rvalid) begin
                    if (flush || discard_reg) begin
                        // Response belongs to a killed fetch: drop it and
                        // refetch from the (redirected) pc_address.
                        discard_next = 1'b0;
                        state_next   = ST_FETCH;
                    end else begin
                        if_instr_next    = imem_rdata;
                        if_pc_next       = req_pc_reg;
                        if_pc_plus4_next = req_pc_reg + 32'd4;
                        if_valid_next    = 1'b1;
                        pc_advance_next  = 1'b1;
                        state_next       = ST_HOLD;
                    end
                end else if (flush) begin
                    // The response is still owed by memory; remember to
                    // swallow it when it arrives.
                    discard_next = 1'b1;
                end
            end

            ST_HOLD: begin
                // Only if_valid drops; the data registers keep their value.
                if (flush || id_ready) begin
                    if_valid_next = 1'b0;
                    state_next    = ST_FETCH;
                end
            end

            default: begin
                state_next    = ST_FETCH;
                discard_next  = 1'b0;
                if_valid_next = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_FETCH;
            discard_reg     <= 1'b0;
            req_pc_reg      <= 32'h0000_0000;
            if_valid_reg    <= 1'b0;
            if_instr_reg    <= 32'h0000_0000;
            if_pc_reg       <= RESET_PC;
            if_pc_plus4_reg <= RESET_PC + 32'd4;
            pc_advance_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            discard_reg     <= discard_next;
            req_pc_reg      <= req_pc_next;
            if_valid_reg    <= if_valid_next;
            if_instr_reg    <= if_instr_next;
            if_pc_reg       <= if_pc_next;
            if_pc_plus4_reg <= if_pc_plus4_next;
            pc_advance_reg  <= pc_advance_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // The address is always the live PC; memory only looks at it while
    // imem_req is high, and program_counter keeps it stable until advanced.
    assign imem_addr   = pc_address;
    assign pc_advance  = pc_advance_reg;
    assign if_valid    = if_valid_reg;
    assign if_instr    = if_instr_reg;
    assign if_pc       = if_pc_reg;
    assign if_pc_plus4 = if_pc_plus4_reg;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_address;
    logic        pc_advance;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    instruction_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_address  (pc_address),
        .pc_advance  (pc_advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .id_ready    (id_ready),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Monitor: every pc_advance pulse must match the oldest expected capture.
    always @(negedge clk) begin
        if (reset === 1'b1 && pc_advance === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_advance: got pc_advance=1 (if_instr %h) want no pulse", if_instr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mon_valid", 32'(if_valid), 32'd1);
                chk("mon_instr", if_instr, mon_e.instr);
                chk("mon_pc", if_pc, mon_e.pc);
                chk("mon_pc4", if_pc_plus4, mon_e.pc4);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts in FETCH just after a posedge; ends just after the edge that
    // captures the response (the pc_advance cycle). Expected pc4 is given
    // explicitly so the wrap case is hand-computed.
    task automatic fetch(input logic [31:0] pc, input logic [31:0] data,
                         input logic [31:0] pc4, input int gwait, input int rwait);
        exp_t e;
        pc_address = pc;
        imem_gnt   = 1'b0;
        repeat (gwait) begin
            @(negedge clk);
            chk("slow_gnt_req", 32'(imem_req), 32'd1);
            chk("slow_gnt_addr", imem_addr, pc);
            tick();
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        chk("gnt_req", 32'(imem_req), 32'd1);
        chk("gnt_addr", imem_addr, pc);
        e.instr = data;
        e.pc    = pc;
        e.pc4   = pc4;
        exp_q.push_back(e);
        tick();
        imem_gnt = 1'b0;
        repeat (rwait) begin
            @(negedge clk);
            chk("wait_req", 32'(imem_req), 32'd0);
            tick();
        end
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
    endtask

    // In the pulse cycle: check the pulse, consume immediately, check return
    // to FETCH with the advanced PC.
    task automatic pulse_consume(input logic [31:0] next_pc);
        id_ready = 1'b1;
        @(negedge clk);
        chk("adv_pulse", 32'(pc_advance), 32'd1);
        tick();
        id_ready   = 1'b0;
        pc_address = next_pc;
        @(negedge clk);
        chk("cons_valid", 32'(if_valid), 32'd0);
        chk("cons_adv", 32'(pc_advance), 32'd0);
        chk("cons_req", 32'(imem_req), 32'd1);
        tick();
    endtask

    initial begin
        // ---------------- reset with random inputs ----------------
        reset = 1'b0;
        repeat (3) begin
            pc_address  = $urandom;
            imem_gnt    = 1'($urandom);
            imem_rvalid = 1'($urandom);
            imem_rdata  = $urandom;
            flush       = 1'($urandom);
            id_ready    = 1'($urandom);
            @(negedge clk);
            chk("rst_valid", 32'(if_valid), 32'd0);
            chk("rst_adv", 32'(pc_advance), 32'd0);
            chk("rst_pc", if_pc, 32'h0000_0000);
            chk("rst_pc4", if_pc_plus4, 32'h0000_0004);
            chk("rst_instr", if_instr, 32'h0000_0000);
            tick();
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        flush       = 1'b0;
        id_ready    = 1'b0;
        reset       = 1'b1;

        // ---------------- basic fetch (grant in first cycle) ----------------
        fetch(32'h0040_0000, 32'h2008_0005, 32'h0040_0004, 0, 0);
        @(negedge clk);
        chk("basic_adv", 32'(pc_advance), 32'd1);
        chk("basic_valid", 32'(if_valid), 32'd1);
        tick();
        pc_address = 32'h0040_0004;

        // ---------------- stall: id_ready low for 5 cycles ----------------
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_instr", if_instr, 32'h2008_0005);
            chk("stall_pc", if_pc, 32'h0040_0000);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_adv", 32'(pc_advance), 32'd0);
            tick();
        end
        id_ready = 1'b1;
        @(negedge clk);
        chk("rel_valid_same", 32'(if_valid), 32'd1);
        tick();
        id_ready = 1'b0;
        @(negedge clk);
        chk("rel_valid_next", 32'(if_valid), 32'd0);
        chk("rel_req", 32'(imem_req), 32'd1);
        tick();

        // ---------------- flush in FETCH, grant must be ignored ----------------
        flush    = 1'b1;
        imem_gnt = 1'b1;
        @(negedge clk);
        chk("fetch_flush_req", 32'(imem_req), 32'd0);
        tick();
        flush    = 1'b0;
        imem_gnt = 1'b0;
        @(negedge clk);
        chk("fetch_flush_stay", 32'(imem_req), 32'd1);
        tick();

        // ---------------- flush in WAIT (repeated), late DEADBEEF ----------------
        pc_address = 32'h0040_0008;
        imem_gnt   = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush    = 1'b1;
        @(negedge clk);
        chk("wflush_req", 32'(imem_req), 32'd0);
        tick();
        tick();                         // second flush cycle, discard already set
        flush      = 1'b0;
        pc_address = 32'h0040_0200;     // redirected PC
        @(negedge clk);
        chk("wflush_still_wait", 32'(imem_req), 32'd0);
        tick();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("wflush_valid", 32'(if_valid), 32'd0);
        chk("wflush_adv", 32'(pc_advance), 32'd0);
        chk("wflush_req_after", 32'(imem_req), 32'd1);
        chk("wflush_redirect", imem_addr, 32'h0040_0200);
        tick();
        fetch(32'h0040_0200, 32'h8C09_0010, 32'h0040_0204, 1, 2);
        pulse_consume(32'h0040_0204);

        // ---------------- flush and rvalid together in WAIT ----------------
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        flush       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        tick();
        flush       = 1'b0;
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("simul_wait_valid", 32'(if_valid), 32'd0);
        chk("simul_wait_adv", 32'(pc_advance), 32'd0);
        chk("simul_wait_req", 32'(imem_req), 32'd1);
        tick();

        // ---------------- flush and id_ready together in HOLD ----------------
        fetch(32'h0040_0300, 32'h0109_5020, 32'h0040_0304, 0, 0);
        @(negedge clk);
        chk("hold_adv", 32'(pc_advance), 32'd1);
        tick();
        pc_address = 32'h0040_0304;
        flush      = 1'b1;
        id_ready   = 1'b1;
        tick();
        flush    = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        chk("hold_flush_valid", 32'(if_valid), 32'd0);
        chk("hold_flush_instr", if_instr, 32'h0109_5020);
        chk("hold_flush_pc", if_pc, 32'h0040_0300);
        chk("hold_flush_req", 32'(imem_req), 32'd1);
        tick();

        // ---------------- wrap with slow grant and slow response ----------------
        fetch(32'hFFFF_FFFC, 32'h0810_0000, 32'h0000_0000, 4, 3);
        pulse_consume(32'h0040_0400);

        // ---------------- zero-wait fetch, id_ready held high ----------------
        id_ready = 1'b1;
        fetch(32'h0040_0400, 32'h0000_0020, 32'h0040_0404, 0, 0);
        pulse_consume(32'h0040_0404);

        // ---------------- reset mid-fetch, late response ignored ----------------
        pc_address = 32'h0040_0500;
        imem_gnt   = 1'b1;
        tick();
        imem_gnt = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        chk("midrst_pc", if_pc, 32'h0000_0000);
        tick();
        reset       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBADC_0DE5;
        @(negedge clk);
        chk("midrst_req", 32'(imem_req), 32'd1);
        tick();
        imem_rvalid = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 32'(if_valid), 32'd0);
        chk("midrst_adv", 32'(pc_advance), 32'd0);
        chk("midrst_instr", if_instr, 32'h0000_0000);
        tick();

        // Every expected capture must have produced a pulse.
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule
